// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small ready/valid FIFO; frame format and line
// rate are fixed by parameters, frames stream back to back with no idle gap.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [DATA_BITS-1:0]        i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic                        o_uart,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);
    localparam int BAUD_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int CW          = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = AW + 1;
    localparam logic [CW-1:0]    BAUD_LOAD  = CW'(BAUD_PERIOD - 1);
    localparam logic [3:0]       LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP  = 4'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        baud_cnt_r;
    logic [3:0]           bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 parity_r;
    logic                 uart_r;
    logic                 busy_r;

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]     count_r;

    logic                 push_s;
    logic                 pop_s;
    logic                 frame_end_s;
    logic                 line_s;
    logic [DATA_BITS-1:0] head_s;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
        if (PARITY == 1) begin
            return ~^data;
        end else begin
            return ^data;
        end
    endfunction

    assign o_ready = (count_r != FULL_COUNT);
    assign push_s  = i_valid && o_ready;
    assign head_s  = mem_r[rd_ptr_r];
    assign o_uart  = uart_r;
    assign o_busy  = busy_r;
    assign o_count = count_r;

    // Pop decision: only when idle or on the very last cycle of the stop bits.
    always_comb begin
        frame_end_s = (state_r == ST_STOP) && (baud_cnt_r == '0) && (bit_cnt_r == LAST_STOP);
        if ((state_r == ST_IDLE) || frame_end_s) begin
            pop_s = (count_r != '0);
        end else begin
            pop_s = 1'b0;
        end
    end

    // Line level implied by the current FSM state.
    always_comb begin
        case (state_r)
            ST_IDLE:   line_s = 1'b1;
            ST_START:  line_s = 1'b0;
            ST_DATA:   line_s = shift_r[0];
            ST_PARITY: line_s = parity_r;
            ST_STOP:   line_s = 1'b1;
            default:   line_s = 1'b1;
        endcase
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= i_data;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Transmit FSM; line and busy are registered one cycle behind the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= '0;
            parity_r   <= 1'b0;
            uart_r     <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            uart_r <= line_s;
            busy_r <= (state_r != ST_IDLE);
            if (pop_s) begin
                shift_r    <= head_s;
                parity_r   <= parity_bit(head_s);
                baud_cnt_r <= BAUD_LOAD;
                bit_cnt_r  <= 4'd0;
                state_r    <= ST_START;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_START: begin
                        if (baud_cnt_r == '0) begin
                            baud_cnt_r <= BAUD_LOAD;
                            state_r    <= ST_DATA;
                        end else begin
                            baud_cnt_r <= baud_cnt_r - 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (baud_cnt_r == '0) begin
                            baud_cnt_r <= BAUD_LOAD;
                            shift_r    <= {1'b0, shift_r[DATA_BITS-1:1]};
                            if (bit_cnt_r == LAST_DATA) begin
                                bit_cnt_r <= 4'd0;
                                state_r   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end else begin
                            baud_cnt_r <= baud_cnt_r - 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (baud_cnt_r == '0) begin
                            baud_cnt_r <= BAUD_LOAD;
                            bit_cnt_r  <= 4'd0;
                            state_r    <= ST_STOP;
                        end else begin
                            baud_cnt_r <= baud_cnt_r - 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (baud_cnt_r == '0) begin
                            if (bit_cnt_r == LAST_STOP) begin
                                state_r <= ST_IDLE;
                            end else begin
                                bit_cnt_r  <= bit_cnt_r + 4'd1;
                                baud_cnt_r <= BAUD_LOAD;
                            end
                        end else begin
                            baud_cnt_r <= baud_cnt_r - 1'b1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-format table over five builds, then a
// queue-based line model driving directed and random traffic on the 8N1 build.
module tb_uart_tx_fifo;
    localparam int ML = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] tdata;
    logic [4:0] valid_v;
    logic [4:0] uart_w;
    logic [4:0] busy_w;
    logic [4:0] ready_w;
    logic [2:0] cnt_w [5];

    int total = 0;
    int bad   = 0;
    int e     = 0;
    int mq[$];
    int cw    = 0;
    int pw    = 0;
    int p     = -1000;
    int pprev = -1000;

    typedef struct {
        string name;
        int    inst;
        int    data;
        int    db;
        int    par;
        int    sb;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_main (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(tdata[7:0]), .i_valid(valid_v[0]),
        .o_ready(ready_w[0]), .o_uart(uart_w[0]), .o_busy(busy_w[0]), .o_count(cnt_w[0]));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(tdata[7:0]), .i_valid(valid_v[1]),
        .o_ready(ready_w[1]), .o_uart(uart_w[1]), .o_busy(busy_w[1]), .o_count(cnt_w[1]));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(tdata[7:0]), .i_valid(valid_v[2]),
        .o_ready(ready_w[2]), .o_uart(uart_w[2]), .o_busy(busy_w[2]), .o_count(cnt_w[2]));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_n2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(tdata[6:0]), .i_valid(valid_v[3]),
        .o_ready(ready_w[3]), .o_uart(uart_w[3]), .o_busy(busy_w[3]), .o_count(cnt_w[3]));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_f1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(tdata[4:0]), .i_valid(valid_v[4]),
        .o_ready(ready_w[4]), .o_uart(uart_w[4]), .o_busy(busy_w[4]), .o_count(cnt_w[4]));

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        e++;
        #1;
    endtask

    // Bit j of a frame: start, data LSB first, optional parity, then stop/idle.
    function automatic logic frame_bit(input int w, input int j, input int db, input int par);
        int ones;
        ones = $countones(w & ((1 << db) - 1));
        if (j == 0) return 1'b0;
        if (j <= db) return 1'((w >> (j - 1)) & 1);
        if (par != 0 && j == db + 1) return (par == 2) ? 1'(ones % 2) : 1'((ones + 1) % 2);
        return 1'b1;
    endfunction

    // One clock of the 8N1 build, checked against the queue model.
    task automatic cycle(input bit v, input int d);
        bit   acc;
        bit   pp;
        int   t;
        int   tp;
        logic el;
        logic eb;
        acc = v && (mq.size() != 4);
        pp  = (mq.size() != 0) && (e + 1 >= p + ML);
        check($sformatf("ready@%0d", e + 1), int'(ready_w[0]), int'(mq.size() != 4));
        tdata      = 9'(d);
        valid_v[0] = v;
        tick();
        valid_v[0] = 1'b0;
        if (pp) begin
            pw    = cw;
            pprev = p;
            cw    = mq.pop_front();
            p     = e;
        end
        if (acc) mq.push_back(d & 255);
        t  = e - 1 - p;
        tp = e - 1 - pprev;
        el = 1'b1;
        eb = 1'b0;
        if (t >= 0 && t < ML) begin
            el = frame_bit(cw, t / 10, 8, 0);
            eb = 1'b1;
        end else if (tp >= 0 && tp < ML) begin
            el = frame_bit(pw, tp / 10, 8, 0);
            eb = 1'b1;
        end
        check($sformatf("line@%0d", e), int'(uart_w[0]), int'(el));
        check($sformatf("busy@%0d", e), int'(busy_w[0]), int'(eb));
        check($sformatf("count@%0d", e), int'(cnt_w[0]), mq.size());
    endtask

    task automatic model_reset();
        mq.delete();
        p     = -1000;
        pprev = -1000;
    endtask

    initial begin
        int   d;
        int   n;
        int   acc_at;
        bit   willacc;
        int   len;
        int   wbad;
        int   bcnt;
        int   ins;
        logic exp_l;

        vecs[0] = '{"8N1_A5", 0, 'hA5, 8, 0, 1};
        vecs[1] = '{"8E1_07", 1, 'h07, 8, 2, 1};
        vecs[2] = '{"8O1_07", 2, 'h07, 8, 1, 1};
        vecs[3] = '{"7N2_7F", 3, 'h7F, 7, 0, 2};
        vecs[4] = '{"5N1_15", 4, 'h15, 5, 0, 1};

        rst_n   = 1'b0;
        tdata   = 9'd0;
        valid_v = 5'd0;
        repeat (3) tick();
        check("rst uart", int'(uart_w[0]), 1);
        check("rst busy", int'(busy_w[0]), 0);
        check("rst ready", int'(ready_w[0]), 1);
        check("rst count", int'(cnt_w[0]), 0);
        rst_n = 1'b1;
        tick();

        // Frame-format table: waveform relative to the push edge and busy length.
        for (int r = 0; r < 5; r++) begin
            ins          = vecs[r].inst;
            len          = (1 + vecs[r].db + (vecs[r].par != 0 ? 1 : 0) + vecs[r].sb) * 10;
            tdata        = 9'(vecs[r].data);
            valid_v[ins] = 1'b1;
            tick();
            valid_v[ins] = 1'b0;
            wbad = 0;
            bcnt = 0;
            for (int k = 1; k <= len + 4; k++) begin
                tick();
                exp_l = (k >= 2 && k < 2 + len) ?
                        frame_bit(vecs[r].data, (k - 2) / 10, vecs[r].db, vecs[r].par) : 1'b1;
                if (uart_w[ins] !== exp_l) wbad++;
                if (busy_w[ins] === 1'b1) bcnt++;
            end
            check({vecs[r].name, " wave errors"}, wbad, 0);
            check({vecs[r].name, " busy cycles"}, bcnt, len);
        end

        model_reset();
        // Hold valid with 0x01..0x06; 0x06 waits for the first pop from a full FIFO.
        d      = 1;
        n      = 0;
        acc_at = -1;
        while (d <= 6 && n < 200) begin
            n++;
            willacc = (mq.size() != 4);
            cycle(1'b1, d);
            if (n == 5) begin
                check("fill count", int'(cnt_w[0]), 4);
                check("fill ready", int'(ready_w[0]), 0);
            end
            if (willacc) begin
                if (d == 6) acc_at = n;
                d++;
            end
        end
        check("word6 accept cycle", acc_at, 103);
        repeat (650) cycle(1'b0, 0);

        // Push while the stream pops at the end of STOP with two words queued.
        cycle(1'b1, 'h11);
        cycle(1'b1, 'h22);
        cycle(1'b1, 'h33);
        repeat (98) cycle(1'b0, 0);
        check("pushpop count before", int'(cnt_w[0]), 2);
        cycle(1'b1, 'h44);
        check("pushpop count after", int'(cnt_w[0]), 2);
        repeat (450) cycle(1'b0, 0);

        // Reset during data bit 3 of 0x3C, then a clean 0x81 frame.
        cycle(1'b1, 'h3C);
        repeat (45) cycle(1'b0, 0);
        check("mid busy before rst", int'(busy_w[0]), 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid rst uart", int'(uart_w[0]), 1);
        check("mid rst busy", int'(busy_w[0]), 0);
        check("mid rst count", int'(cnt_w[0]), 0);
        check("mid rst ready", int'(ready_w[0]), 1);
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 'h81);
        repeat (110) cycle(1'b0, 0);

        // Random traffic: sparse, then dense enough to keep the FIFO full.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 99) < 3), int'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 1000; i++) begin
            cycle(($urandom_range(0, 99) < 30), int'($urandom_range(0, 255)));
        end
        repeat (500) cycle(1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
